// File: rtl/mem_copy_engine_if.sv
// Command and data-memory bus for the memory copy/fill engine.
// The slave modport is the engine side; the master modport is the requester/memory side.
`timescale 1ns/1ps
interface mem_copy_engine_if;
  logic       i_start;
  logic       i_mode;
  logic [7:0] i_src_addr;
  logic [7:0] i_dst_addr;
  logic [7:0] i_length;
  logic [7:0] i_fill_value;
  logic [7:0] i_mem_data_out;
  logic [7:0] o_mem_address;
  logic       o_mem_write_enable;
  logic [7:0] o_mem_data_in;
  logic       o_busy;
  logic       o_done;

  modport slave (
    input  i_start, i_mode, i_src_addr, i_dst_addr, i_length, i_fill_value, i_mem_data_out,
    output o_mem_address, o_mem_write_enable, o_mem_data_in, o_busy, o_done
  );

  modport master (
    output i_start, i_mode, i_src_addr, i_dst_addr, i_length, i_fill_value, i_mem_data_out,
    input  o_mem_address, o_mem_write_enable, o_mem_data_in, o_busy, o_done
  );
endinterface

// File: rtl/mem_copy_engine.sv
// Byte-wise copy/fill engine for a 256 x 8 data memory: one READ+WRITE pair per
// byte in copy mode, one WRITE per byte in fill mode, 8-bit wrapping addresses.
`timescale 1ns/1ps
module mem_copy_engine (
  input  logic             i_clk,
  input  logic             i_reset,
  mem_copy_engine_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic       r_mode;
  logic [7:0] r_src;
  logic [7:0] r_dst;
  logic [7:0] r_len;
  logic [7:0] r_fill;
  logic [7:0] r_idx;
  logic [7:0] r_buf;
  logic       w_last;
  logic [7:0] w_src_addr;
  logic [7:0] w_dst_addr;

  // Length is never zero in WRITE, so len-1 cannot underflow where it matters.
  assign w_last     = (r_idx == (r_len - 8'd1));
  assign w_src_addr = r_src + r_idx;
  assign w_dst_addr = r_dst + r_idx;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Command latch, byte index and copy buffer
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mode <= 1'b0;
      r_src  <= 8'd0;
      r_dst  <= 8'd0;
      r_len  <= 8'd0;
      r_fill <= 8'd0;
      r_idx  <= 8'd0;
      r_buf  <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_mode <= bus.i_mode;
            r_src  <= bus.i_src_addr;
            r_dst  <= bus.i_dst_addr;
            r_len  <= bus.i_length;
            r_fill <= bus.i_fill_value;
            r_idx  <= 8'd0;
          end
        end
        S_READ: begin
          r_buf <= bus.i_mem_data_out;
        end
        S_WRITE: begin
          if (!w_last) begin
            r_idx <= r_idx + 8'd1;
          end
        end
        default: begin
          r_idx <= r_idx;
        end
      endcase
    end
  end

  // Next-state decode; start is only honoured in IDLE
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (!bus.i_start) begin
          w_next_state = S_IDLE;
        end else if (bus.i_length == 8'd0) begin
          w_next_state = S_DONE;
        end else if (bus.i_mode) begin
          w_next_state = S_WRITE;
        end else begin
          w_next_state = S_READ;
        end
      end
      S_READ: begin
        w_next_state = S_WRITE;
      end
      S_WRITE: begin
        if (w_last) begin
          w_next_state = S_DONE;
        end else if (r_mode) begin
          w_next_state = S_WRITE;
        end else begin
          w_next_state = S_READ;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Output decode from registered state and counters only
  always_comb begin
    bus.o_mem_address      = 8'd0;
    bus.o_mem_write_enable = 1'b0;
    bus.o_mem_data_in      = 8'd0;
    bus.o_busy             = 1'b0;
    bus.o_done             = 1'b0;
    case (r_state)
      S_READ: begin
        bus.o_mem_address = w_src_addr;
        bus.o_busy        = 1'b1;
      end
      S_WRITE: begin
        bus.o_mem_address      = w_dst_addr;
        bus.o_mem_write_enable = 1'b1;
        bus.o_mem_data_in      = r_mode ? r_fill : r_buf;
        bus.o_busy             = 1'b1;
      end
      S_DONE: begin
        bus.o_done = 1'b1;
      end
      default: begin
        bus.o_busy = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a 256 x 8 memory model and a write scoreboard.
`timescale 1ns/1ps
module tb_mem_copy_engine;
  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       pl_en;
  logic [7:0] pl_addr;
  logic [7:0] pl_data;
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  wr_t        sb [$];
  int         checks = 0;
  int         failures = 0;
  int         lat, nwr, dcnt, bcnt;

  mem_copy_engine_if bus ();

  mem_copy_engine dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  assign bus.i_mem_data_out = mem[bus.o_mem_address];

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (bus.o_mem_write_enable) begin
      mem[bus.o_mem_address] <= bus.o_mem_data_in;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_en = 1'b1;
    pl_addr = a;
    pl_data = d;
    ref_mem[a] = d;
  endtask

  task automatic push_copy(input logic [7:0] s, input logic [7:0] d, input int l);
    for (int i = 0; i < l; i++) begin
      logic [7:0] a;
      a = 8'(d + i);
      ref_mem[a] = ref_mem[8'(s + i)];
      sb.push_back('{addr: a, data: ref_mem[a]});
    end
  endtask

  task automatic push_fill(input logic [7:0] d, input int l, input logic [7:0] f);
    for (int i = 0; i < l; i++) begin
      logic [7:0] a;
      a = 8'(d + i);
      ref_mem[a] = f;
      sb.push_back('{addr: a, data: f});
    end
  endtask

  task automatic run_cmd(input logic m, input logic [7:0] s, input logic [7:0] d,
                         input logic [7:0] l, input logic [7:0] f, input int hold,
                         input int inj_at, input int rst_after, input int win,
                         output int o_lat, output int o_nwr, output int o_dcnt, output int o_bcnt);
    bit rst_pend;
    wr_t e;
    @(negedge clk);
    pl_en = 1'b0;
    bus.i_start = 1'b1;
    bus.i_mode = m;
    bus.i_src_addr = s;
    bus.i_dst_addr = d;
    bus.i_length = l;
    bus.i_fill_value = f;
    o_lat = -1; o_nwr = 0; o_dcnt = 0; o_bcnt = 0; rst_pend = 1'b0;
    for (int k = 1; k <= win; k++) begin
      @(negedge clk);
      if (rst_pend) begin
        chk("rst_outputs", {bus.o_mem_address, bus.o_mem_write_enable, bus.o_mem_data_in,
                            bus.o_busy, bus.o_done}, 32'd0);
        rst = 1'b0;
        rst_pend = 1'b0;
      end
      if (bus.o_busy) o_bcnt++;
      if (bus.o_mem_write_enable) begin
        o_nwr++;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("wr_addr", {24'd0, bus.o_mem_address}, {24'd0, e.addr});
          chk("wr_data", {24'd0, bus.o_mem_data_in}, {24'd0, e.data});
        end else begin
          checks++;
          failures++;
          $error("FAIL wr_unexpected observed addr=%0h expected no write", bus.o_mem_address);
        end
      end
      if (bus.o_done) begin
        o_dcnt++;
        if (o_lat < 0) o_lat = k;
      end
      if (rst_after > 0 && bus.o_mem_write_enable && o_nwr == rst_after) begin
        rst = 1'b1;
        rst_pend = 1'b1;
      end
      if (k < hold) begin
        bus.i_start = 1'b1;
      end else if (k == inj_at) begin
        bus.i_start = 1'b1;
        bus.i_mode = ~m;
        bus.i_src_addr = s + 8'h33;
        bus.i_dst_addr = d + 8'h40;
        bus.i_length = 8'd3;
        bus.i_fill_value = ~f;
      end else begin
        bus.i_start = 1'b0;
        bus.i_mode = ~m;
        bus.i_src_addr = ~s;
        bus.i_dst_addr = ~d;
        bus.i_length = ~l;
        bus.i_fill_value = ~f;
      end
    end
    bus.i_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    pl_en = 1'b0;
    pl_addr = 8'd0;
    pl_data = 8'd0;
    bus.i_start = 1'b0;
    bus.i_mode = 1'b0;
    bus.i_src_addr = 8'd0;
    bus.i_dst_addr = 8'd0;
    bus.i_length = 8'd0;
    bus.i_fill_value = 8'd0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset_addr", {24'd0, bus.o_mem_address}, 32'd0);
    chk("reset_we", {31'd0, bus.o_mem_write_enable}, 32'd0);
    chk("reset_data", {24'd0, bus.o_mem_data_in}, 32'd0);
    chk("reset_busy", {31'd0, bus.o_busy}, 32'd0);
    chk("reset_done", {31'd0, bus.o_done}, 32'd0);
    rst = 1'b0;

    // Plain copy of four bytes
    preload(8'h10, 8'hA1); preload(8'h11, 8'hB2); preload(8'h12, 8'hC3); preload(8'h13, 8'hD4);
    for (int i = 0; i < 4; i++) preload(8'(8'h80 + i), 8'h00);
    push_copy(8'h10, 8'h80, 4);
    run_cmd(1'b0, 8'h10, 8'h80, 8'd4, 8'h00, 1, 0, 0, 14, lat, nwr, dcnt, bcnt);
    chk("copy_latency", lat, 32'd9);
    chk("copy_writes", nwr, 32'd4);
    chk("copy_done_pulses", dcnt, 32'd1);
    chk("copy_busy_cycles", bcnt, 32'd8);
    chk("copy_sb_left", sb.size(), 32'd0);
    chk("copy_mem80", {24'd0, mem[8'h80]}, 32'hA1);
    chk("copy_mem81", {24'd0, mem[8'h81]}, 32'hB2);
    chk("copy_mem82", {24'd0, mem[8'h82]}, 32'hC3);
    chk("copy_mem83", {24'd0, mem[8'h83]}, 32'hD4);

    // Fill crossing the top of the address space
    preload(8'hFE, 8'h33); preload(8'hFF, 8'h33); preload(8'h00, 8'h33);
    preload(8'h01, 8'h33); preload(8'h02, 8'h33);
    push_fill(8'hFE, 4, 8'h5A);
    run_cmd(1'b1, 8'h00, 8'hFE, 8'd4, 8'h5A, 1, 0, 0, 10, lat, nwr, dcnt, bcnt);
    chk("fill_latency", lat, 32'd5);
    chk("fill_writes", nwr, 32'd4);
    chk("fill_done_pulses", dcnt, 32'd1);
    chk("fill_sb_left", sb.size(), 32'd0);
    chk("fill_memFE", {24'd0, mem[8'hFE]}, 32'h5A);
    chk("fill_memFF", {24'd0, mem[8'hFF]}, 32'h5A);
    chk("fill_mem00", {24'd0, mem[8'h00]}, 32'h5A);
    chk("fill_mem01", {24'd0, mem[8'h01]}, 32'h5A);
    chk("fill_mem02_untouched", {24'd0, mem[8'h02]}, 32'h33);

    // Zero length, start held into the DONE cycle (second sample must be ignored)
    run_cmd(1'b0, 8'h10, 8'h80, 8'd0, 8'h00, 2, 0, 0, 6, lat, nwr, dcnt, bcnt);
    chk("zero_latency", lat, 32'd1);
    chk("zero_writes", nwr, 32'd0);
    chk("zero_busy_cycles", bcnt, 32'd0);
    chk("zero_done_pulses", dcnt, 32'd1);

    // Overlapping copy forward by one
    preload(8'h20, 8'h11); preload(8'h21, 8'h22); preload(8'h22, 8'h00);
    push_copy(8'h20, 8'h21, 2);
    run_cmd(1'b0, 8'h20, 8'h21, 8'd2, 8'h00, 1, 0, 0, 9, lat, nwr, dcnt, bcnt);
    chk("ovl_latency", lat, 32'd5);
    chk("ovl_mem21", {24'd0, mem[8'h21]}, 32'h11);
    chk("ovl_mem22", {24'd0, mem[8'h22]}, 32'h11);
    chk("ovl_mem20", {24'd0, mem[8'h20]}, 32'h11);

    // Reset after the third write strobe of an eight-byte copy
    for (int i = 0; i < 8; i++) preload(8'(8'h40 + i), 8'(8'hC0 + i));
    for (int i = 0; i < 8; i++) preload(8'(8'h90 + i), 8'hEE);
    push_copy(8'h40, 8'h90, 8);
    run_cmd(1'b0, 8'h40, 8'h90, 8'd8, 8'h00, 1, 0, 3, 20, lat, nwr, dcnt, bcnt);
    chk("rst_writes", nwr, 32'd3);
    chk("rst_done_pulses", dcnt, 32'd0);
    chk("rst_sb_left", sb.size(), 32'd5);
    sb.delete();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rst_mem%0h", 8'h90 + i), {24'd0, mem[8'(8'h90 + i)]},
          (i < 3) ? 32'(8'hC0 + i) : 32'hEE);
    end

    // Start pulse with different arguments in the middle of a fill
    for (int i = 0; i < 7; i++) preload(8'(8'h60 + i), 8'h12);
    preload(8'hA0, 8'h99); preload(8'hA1, 8'h99); preload(8'hA2, 8'h99);
    push_fill(8'h60, 6, 8'h77);
    run_cmd(1'b1, 8'h60, 8'h60, 8'd6, 8'h77, 1, 3, 0, 12, lat, nwr, dcnt, bcnt);
    chk("busy_start_latency", lat, 32'd7);
    chk("busy_start_writes", nwr, 32'd6);
    chk("busy_start_done_pulses", dcnt, 32'd1);
    chk("busy_start_sb_left", sb.size(), 32'd0);
    chk("busy_start_mem60", {24'd0, mem[8'h60]}, 32'h77);
    chk("busy_start_mem65", {24'd0, mem[8'h65]}, 32'h77);
    chk("busy_start_mem66", {24'd0, mem[8'h66]}, 32'h12);
    chk("busy_start_memA0", {24'd0, mem[8'hA0]}, 32'h99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 Parameters: none; address and data widths are fixed at 8 bits, matching the data memory (256 x 8).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 mode  input  1  0 = copy, 1 = fill.
REQ-006 src_addr  input  8  copy source base address.
REQ-007 dst_addr  input  8  destination base address (copy and fill).
REQ-008 length  input  8  byte count; 0 = no transfer.
REQ-009 fill_value  input  8  byte written in fill mode.
REQ-010 mem_data_out  input  8  combinational read data from the data memory at mem_address.
REQ-011 mem_address  output  8  address to the data memory.
REQ-012 mem_write_enable  output  1  write strobe; the memory writes on the rising edge while high.
REQ-013 mem_data_in  output  8  write data to the data memory.
REQ-014 busy  output  1  high in READ and WRITE states.
REQ-015 done  output  1  one-cycle completion pulse.

Function
REQ-016 FSM states: IDLE, READ, WRITE, DONE; all outputs decode from registered state/counters only, with no combinational path from start to any output.
REQ-017 IDLE: when start=1, latch mode, src_addr, dst_addr, length, fill_value; clear index idx to 0; next state is DONE if length=0, WRITE if mode=1, otherwise READ.
REQ-018 Inputs other than mem_data_out are ignored outside the IDLE start edge; start outside IDLE is ignored and not queued.
REQ-019 READ (copy only): mem_address = src+idx (mod 256), mem_write_enable=0; on the edge, capture mem_data_out into buf; next state is WRITE.
REQ-020 WRITE: mem_address = dst+idx (mod 256), mem_write_enable=1, mem_data_in = buf (copy) or fill_value (fill).
REQ-021 WRITE exit: if idx = length-1, next state is DONE; else idx increments and next state is READ (copy) or WRITE (fill).
REQ-022 DONE: done=1, busy=0, mem_write_enable=0 for exactly one cycle; next state is IDLE.
REQ-023 IDLE outputs: mem_address=0, mem_write_enable=0, mem_data_in=0, busy=0, done=0.
REQ-024 Address arithmetic is 8-bit modulo 256; a transfer crossing 0xFF wraps to 0x00 without error.
REQ-025 Latency from the start-sampling edge to done high: copy 2N+1 cycles, fill N+1 cycles, length 0 exactly 1 cycle.
REQ-026 Transfers proceed in ascending idx order, one byte per iteration; overlapping copies with dst>src propagate the earlier-written bytes (defined behaviour, not an error).
REQ-027 A start sampled in the same cycle that DONE returns to IDLE is not accepted; a new start is accepted from the first IDLE cycle onward.

Reset
REQ-028 reset=1 on any edge forces IDLE, sets idx=0 and buf=0, and drives all outputs to the REQ-023 values in the next cycle, overriding start.
REQ-029 reset mid-transfer aborts the transfer: no done pulse, no further writes; bytes already written remain in memory.

Verification
REQ-030 Copy: memory[0x10..0x13]={A1,B2,C3,D4}, start with mode=0, src=0x10, dst=0x80, len=4 -> memory[0x80..0x83]={A1,B2,C3,D4}, done 9 cycles after start, exactly 4 write strobes.
REQ-031 Fill with wrap: mode=1, dst=0xFE, len=4, fill=0x5A -> 0xFE, 0xFF, 0x00, 0x01 all hold 0x5A, done 5 cycles after start, 0x02 unchanged.
REQ-032 Zero length: len=0 -> no write strobe, done high on the cycle after start, busy never high.
REQ-033 Overlap: memory[0x20]=0x11, [0x21]=0x22, copy src=0x20, dst=0x21, len=2 -> [0x21]=0x11, [0x22]=0x11.
REQ-034 Reset mid-copy: len=8, assert reset after the 3rd write strobe -> exactly 3 destination bytes updated, no done pulse, outputs 0 next cycle.
REQ-035 Start while busy: pulse start with different arguments mid-fill -> ignored; original fill completes unaltered with a single done pulse.
